mul_seq_ctrl: RTL
=================

# mul_seq_ctrl

Sequential shift-and-add multiplier controller. It computes an unsigned WIDTH x WIDTH product by iterating one WIDTH-bit adder (with carry-out) over the multiplier bits, one bit per clock. It sits beside the ALU as its multi-cycle multiply unit and uses a start/busy/done handshake toward the ALU control path. The adder datapath stays combinational; this block owns all sequencing, operand and partial-product registers, and the result register.

## Interface
- WIDTH, 32, operand width. It is also the adder width and the iteration count. The product is 2*WIDTH bits.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply. Sampled only in IDLE or DONE.
- multiplicand  in  WIDTH  operand A. Sampled on the accepting edge.
- multiplier  in  WIDTH  operand B. Sampled on the accepting edge.
- busy  out  1  high while iterating (CALC state)
- done  out  1  one-cycle pulse; product is valid from this cycle
- product  out  2*WIDTH  registered result. Held until the next completion.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE: start=1 -> accept, go to CALC. Otherwise stay.
  - CALC: iterate. After the WIDTH-th iteration, go to DONE.
  - DONE: start=1 -> accept, go to CALC. Otherwise go to IDLE.
- Accept edge loads:
  - A_reg <= multiplicand
  - P <= {WIDTH'b0, multiplier}
  - cnt <= 0
- CALC iteration, one per edge:
  - If P[0]=1: {c, s} = P[2W-1:W] + A_reg. Otherwise c=0, s=P[2W-1:W].
  - P <= {c, s, P[W-1:1]}
  - cnt <= cnt+1
- The adder carry-in is tied to 0. The carry-out is kept as the new P MSB, so no bit is lost.
- On the edge completing iteration WIDTH: product <= next P value, state <= DONE.
- Arithmetic is unsigned only. Result is exact modulo 2^(2*WIDTH). No overflow is possible.
- start is ignored while busy=1. Operand changes during CALC have no effect.
- product keeps its old value from accept until the completing edge.
- cnt is $clog2(WIDTH)+1 bits wide, so it can hold the value WIDTH.

## Timing
- Reset (async, rst_n=0) forces immediately, regardless of clock:
  - state=IDLE, busy=0, done=0, product=0, A_reg=0, P=0, cnt=0
- Reset mid-CALC abandons the operation. product reads 0, not the previous result.
- Deassertion: start can be accepted on the first rising edge with rst_n=1.
- Let edge 0 be the accepting edge.
  - busy=1 from after edge 0 through edge WIDTH: exactly WIDTH cycles.
  - Edges 1..WIDTH perform the iterations.
  - After edge WIDTH: busy=0, done=1, product valid.
  - done drops after edge WIDTH+1.
- Latency from accept to done is WIDTH+1 edges (33 at default). Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start=1 during the DONE cycle: accepted at that edge. done drops and busy rises after the edge. product still holds the previous result until the new completion.
- busy and done are never high together. All outputs are registered; none are combinational from inputs.

## Test plan
- Basic multiply: reset, then start with A=0x00000003, B=0x00000005.
  - busy high for 32 cycles.
  - done pulses for exactly 1 cycle, 33 edges after accept.
  - product=0x0000_0000_0000_000F.
- Carry path: A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0xFFFFFFFE_00000001.
  - Also A=0x80000000, B=0x00000002 -> product=0x0000_0001_0000_0000.
- Zero operands: A=0, B=0x12345678 -> product=0. Then A=0xDEADBEEF, B=0 -> product=0. Each completes in full 33-edge latency.
- Protocol:
  - Pulse start again with different operands at cycle 10 of CALC -> ignored. The result matches the first operands.
  - With start held high, 3x4 then 7x9 back-to-back -> done pulses 33 edges apart, product=0xC then 0x3F.
  - product holds 0xC throughout the second CALC.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) at iteration 16 of 0x1234*0x5678.
  - busy, done, product drop to 0 immediately.
  - After release, a new start 2x2 -> product=4 with normal latency.
- Random regression: 1000 random A/B pairs, including all-ones/power-of-two corners, random start gaps and back-to-back starts.
  - Compare product to a 64-bit reference at each done.
  - Check busy=WIDTH cycles and that busy and done are never high together.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add multiplier: one WIDTH-bit add per clock, with
// a start/busy/done handshake and a registered 2*WIDTH-bit product.
module mul_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [PW-1:0]      p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      product_d;
    logic               busy_d, done_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     part;
    logic [PW-1:0]      p_iter;

    // One shift-and-add step; the adder carry-out becomes the new P MSB.
    always_comb begin
        add_sum = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, a_q};
        part    = p_q[0] ? add_sum : {1'b0, p_q[PW-1:WIDTH]};
        p_iter  = {part, p_q[WIDTH-1:1]};
    end

    // Next-state and next-register values.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = multiplicand;
                    p_d     = {{WIDTH{1'b0}}, multiplier};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                p_d   = p_iter;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = p_iter;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = multiplicand;
                    p_d     = {{WIDTH{1'b0}}, multiplier};
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            product <= product_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
